// File: rtl/cbus_arbiter.sv
// cbus_arbiter -- round-robin arbiter that multiplexes N cbus masters onto
// one downstream cbus port (memory model / AXI bridge side).
//
// A master is granted from IDLE one cycle after it raises valid, and it keeps
// the grant until the downstream slave handshakes the final beat
// (oresp.ready && oresp.last). The arbiter then spends one cycle in IDLE, so
// oreq.valid is low for at least one cycle between bursts. While BUSY, the
// granted request is passed straight through with no buffering, and the slave
// response goes only to the granted master.
//
// Handshake: a beat transfers on a rising clk edge where oreq.valid and
// oresp.ready are both 1. A master keeps valid and all request fields stable
// until its last beat. The slave marks the final beat with oresp.last.
//
// Optional feature (macro CBUS_ARB_WATCHDOG_EN): a per-burst cycle counter
// sets the sticky timeout flag once a burst has been BUSY for
// TIMEOUT_CYCLES cycles. Without the macro, timeout is tied to 0.
//
// Parameters:
//   N_MASTERS       number of upstream masters (2..8)
//   TIMEOUT_CYCLES  watchdog limit per burst (watchdog build only)
// Ports:
//   clk        clock
//   reset      asynchronous active-high reset
//   ireqs      upstream requests, one per master
//   iresps     upstream responses, one per master
//   oreq       request to the downstream slave
//   oresp      response from the downstream slave
//   timeout    sticky watchdog flag
//   state_dbg  current FSM state (0 = IDLE, 1 = BUSY)

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
    logic [1:0]  burst;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int N_MASTERS      = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [N_MASTERS],
  output cbus_resp_t iresps [N_MASTERS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp,
  output logic       timeout,
  output logic       state_dbg
);

  localparam int IDX_W = $clog2(N_MASTERS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   index, index_d;
  logic [IDX_W-1:0]   last_grant, last_grant_d;

  logic [N_MASTERS-1:0] valids;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;

  // Index offset k places after lg, wrapping mod N_MASTERS. Done in int so a
  // non-power-of-two N wraps at N rather than at 2**IDX_W.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] lg,
                                               input int k);
    int s;
    s = (int'(lg) + k) % N_MASTERS;
    return s[IDX_W-1:0];
  endfunction

  always_comb begin
    valids = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      valids[i] = ireqs[i].valid;
    end
  end

  // Scan last_grant+1 upward with wrap; last_grant itself is looked at last,
  // so a master cannot win twice in a row while another is requesting.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      if (!pick_found && valids[rr_next(last_grant, k)]) begin
        pick_found = 1'b1;
        pick_idx   = rr_next(last_grant, k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      index      <= '0;
      last_grant <= IDX_W'(N_MASTERS - 1);
    end else begin
      state      <= state_d;
      index      <= index_d;
      last_grant <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state;
    index_d      = index;
    last_grant_d = last_grant;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          index_d = pick_idx;
        end
      end
      BUSY: begin
        // Exit depends only on the slave; a master that drops valid
        // mid-burst does not release the grant.
        if (oresp.ready && oresp.last) begin
          state_d      = IDLE;
          last_grant_d = index;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on the registered state only, so an asynchronous reset
  // zeroes them immediately without waiting for a clock edge.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      iresps[i] = '0;
    end
    if (state == BUSY) begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (IDX_W'(i) == index) begin
          oreq      = ireqs[i];
          iresps[i] = oresp;
        end
      end
    end
  end

  assign state_dbg = state;

`ifdef CBUS_ARB_WATCHDOG_EN
  logic [31:0] wdog;
  logic        timeout_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && state_d == BUSY) begin
        wdog <= '0;
      end else if (state == BUSY) begin
        wdog <= wdog + 32'd1;
        if (wdog + 32'd1 == 32'(TIMEOUT_CYCLES) && !timeout_q) begin
          timeout_q <= 1'b1;
`ifndef SYNTHESIS
          $display("cbus_arbiter: timeout master %d addr %x", index, oreq.addr);
`endif
        end
      end
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^32'(TIMEOUT_CYCLES);
  assign timeout         = 1'b0;
`endif

endmodule
